// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Optional perf counters in pipeline_ctrl are enabled by PIPELINE_CTRL_PERF_EN.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    // True when an ID-stage source really reads the register a load is producing.
    function automatic logic src_hit(input logic use_rs, input logic [4:0] rs,
                                     input logic [4:0] rd);
        return use_rs && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle: stage info from the pipeline (master) and the
// stall/flush/forward controls returned by pipeline_ctrl (slave).
interface pipeline_ctrl_if;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       use_rs1_id;
    logic       use_rs2_id;
    logic [4:0] rs1_ex;
    logic [4:0] rs2_ex;
    logic [4:0] rd_ex;
    logic       memread_ex;
    logic [4:0] rd_mem;
    logic       regwrite_mem;
    logic [4:0] rd_wb;
    logic       regwrite_wb;
    logic       branch_taken_ex;
    logic       dmem_req;
    logic       dmem_ready;

    logic       stall_if;
    logic       stall_id;
    logic       bubble_ex;
    logic       flush_ifid;
    logic       flush_idex;
    logic       freeze;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mem_timeout;
    logic [1:0] ctrl_state;

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rs1_ex, rs2_ex, rd_ex,
               memread_ex, rd_mem, regwrite_mem, rd_wb, regwrite_wb,
               branch_taken_ex, dmem_req, dmem_ready,
        input  stall_if, stall_id, bubble_ex, flush_ifid, flush_idex, freeze,
               fwd_a, fwd_b, mem_timeout, ctrl_state
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rs1_ex, rs2_ex, rd_ex,
               memread_ex, rd_mem, regwrite_mem, rd_wb, regwrite_wb,
               branch_taken_ex, dmem_req, dmem_ready,
        output stall_if, stall_id, bubble_ex, flush_ifid, flush_idex, freeze,
               fwd_a, fwd_b, mem_timeout, ctrl_state
    );
endinterface

// File: rtl/pipeline_ctrl_fwd_sel.sv
// ALU operand forwarding select for one EX-stage source register.
module fwd_sel
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_mem,
    input  logic       regwrite_mem,
    input  logic [4:0] rd_wb,
    input  logic       regwrite_wb,
    output logic [1:0] sel
);

    // EX/MEM is the younger result, so it overrides MEM/WB; x0 is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (regwrite_wb && (rd_wb != REG_X0) && (rd_wb == rs))
            sel = FWD_WB;
        if (regwrite_mem && (rd_mem != REG_X0) && (rd_mem == rs))
            sel = FWD_MEM;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Define PIPELINE_CTRL_PERF_EN to add the perf_stall_cnt/perf_flush_cnt counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    pipeline_ctrl_if.slave bus
);

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    ctrl_state_t state;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_nxt;
    logic        timeout_q;

    logic        load_use;
    logic        freeze_c;
    logic        flush_c;
    logic        stall_c;
    logic [1:0]  fwd_a_c;
    logic [1:0]  fwd_b_c;

    fwd_sel u_fwd_a (
        .rs           (bus.rs1_ex),
        .rd_mem       (bus.rd_mem),
        .regwrite_mem (bus.regwrite_mem),
        .rd_wb        (bus.rd_wb),
        .regwrite_wb  (bus.regwrite_wb),
        .sel          (fwd_a_c)
    );

    fwd_sel u_fwd_b (
        .rs           (bus.rs2_ex),
        .rd_mem       (bus.rd_mem),
        .regwrite_mem (bus.regwrite_mem),
        .rd_wb        (bus.rd_wb),
        .regwrite_wb  (bus.regwrite_wb),
        .sel          (fwd_b_c)
    );

    // Priority freeze > flush > load-use; a branch held in EX by a freeze is
    // taken on the MEM_WAIT exit cycle, which is the first unfrozen cycle.
    always_comb begin
        load_use = bus.memread_ex && (bus.rd_ex != REG_X0) &&
                   (src_hit(bus.use_rs1_id, bus.rs1_id, bus.rd_ex) ||
                    src_hit(bus.use_rs2_id, bus.rs2_id, bus.rd_ex));
        freeze_c     = 1'b0;
        flush_c      = 1'b0;
        stall_c      = 1'b0;
        wait_cnt_nxt = 8'd0;
        case (state)
            ST_RUN: begin
                freeze_c     = bus.dmem_req && !bus.dmem_ready;
                flush_c      = !freeze_c && bus.branch_taken_ex;
                stall_c      = !freeze_c && !flush_c && load_use;
                wait_cnt_nxt = freeze_c ? 8'd1 : 8'd0;
            end
            ST_MEM_WAIT: begin
                freeze_c = !bus.dmem_ready;
                flush_c  = !freeze_c && bus.branch_taken_ex;
                if (freeze_c)
                    wait_cnt_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
            end
            ST_FLUSH: begin
                // ID holds a squashed slot, so no load-use check and no new branch.
                freeze_c = bus.dmem_req && !bus.dmem_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            if ((wait_cnt_nxt != 8'd0) && (wait_cnt_nxt >= LIMIT))
                timeout_q <= 1'b1;
            case (state)
                ST_RUN: begin
                    if (freeze_c)
                        state <= ST_MEM_WAIT;
                    else if (flush_c)
                        state <= ST_FLUSH;
                end
                ST_MEM_WAIT: begin
                    if (!freeze_c)
                        state <= flush_c ? ST_FLUSH : ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Every control output reads 0 for as long as reset is held.
    assign bus.stall_if    = !reset && stall_c;
    assign bus.stall_id    = !reset && stall_c;
    assign bus.bubble_ex   = !reset && stall_c;
    assign bus.flush_ifid  = !reset && flush_c;
    assign bus.flush_idex  = !reset && flush_c;
    assign bus.freeze      = !reset && freeze_c;
    assign bus.fwd_a       = reset ? FWD_RF : fwd_a_c;
    assign bus.fwd_b       = reset ? FWD_RF : fwd_b_c;
    assign bus.mem_timeout = timeout_q;
    assign bus.ctrl_state  = state;

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall_c || freeze_c)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_c)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus ();

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    pipeline_ctrl #(.WAIT_LIMIT(16)) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef PIPELINE_CTRL_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .bus            (bus)
    );

    typedef struct packed {
        logic [4:0] rs1_id;
        logic [4:0] rs2_id;
        logic       use1;
        logic       use2;
        logic [4:0] rs1_ex;
        logic [4:0] rs2_ex;
        logic [4:0] rd_ex;
        logic       memread;
        logic [4:0] rd_mem;
        logic       rwm;
        logic [4:0] rd_wb;
        logic       rwb;
        logic       br;
        logic       req;
        logic       rdy;
    } ins_t;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic       frz;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       to;
        logic [1:0] st;
    } exp_t;

    typedef struct packed {
        ins_t in;
        exp_t ex;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic drive(input ins_t v);
        bus.rs1_id          = v.rs1_id;
        bus.rs2_id          = v.rs2_id;
        bus.use_rs1_id      = v.use1;
        bus.use_rs2_id      = v.use2;
        bus.rs1_ex          = v.rs1_ex;
        bus.rs2_ex          = v.rs2_ex;
        bus.rd_ex           = v.rd_ex;
        bus.memread_ex      = v.memread;
        bus.rd_mem          = v.rd_mem;
        bus.regwrite_mem    = v.rwm;
        bus.rd_wb           = v.rd_wb;
        bus.regwrite_wb     = v.rwb;
        bus.branch_taken_ex = v.br;
        bus.dmem_req        = v.req;
        bus.dmem_ready      = v.rdy;
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, " stall_if"},    32'(bus.stall_if),    32'(e.stall));
        chk({tag, " stall_id"},    32'(bus.stall_id),    32'(e.stall));
        chk({tag, " bubble_ex"},   32'(bus.bubble_ex),   32'(e.stall));
        chk({tag, " flush_ifid"},  32'(bus.flush_ifid),  32'(e.flush));
        chk({tag, " flush_idex"},  32'(bus.flush_idex),  32'(e.flush));
        chk({tag, " freeze"},      32'(bus.freeze),      32'(e.frz));
        chk({tag, " fwd_a"},       32'(bus.fwd_a),       32'(e.fa));
        chk({tag, " fwd_b"},       32'(bus.fwd_b),       32'(e.fb));
        chk({tag, " mem_timeout"}, 32'(bus.mem_timeout), 32'(e.to));
        chk({tag, " ctrl_state"},  32'(bus.ctrl_state),  32'(e.st));
    endtask

    // Behavioural model state
    bit m_waiting;
    bit m_flush_slot;
    int m_wait_cycles;
    bit m_timed_out;
    longint m_stall_cnt;
    longint m_flush_cnt;

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input ins_t v);
        if (v.rwm && v.rd_mem != 0 && v.rd_mem == rs) return 2'b01;
        if (v.rwb && v.rd_wb != 0 && v.rd_wb == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic exp_t model_exp(input ins_t v);
        exp_t e;
        bit hazard;
        hazard = v.memread && v.rd_ex != 0 &&
                 ((v.use1 && v.rs1_id == v.rd_ex) || (v.use2 && v.rs2_id == v.rd_ex));
        e.frz   = m_waiting ? !v.rdy : (v.req && !v.rdy);
        e.flush = !e.frz && v.br && !m_flush_slot;
        e.stall = !e.frz && !e.flush && hazard && !m_flush_slot && !m_waiting;
        e.fa    = fwd_ref(v.rs1_ex, v);
        e.fb    = fwd_ref(v.rs2_ex, v);
        e.to    = m_timed_out;
        e.st    = m_waiting ? 2'b01 : (m_flush_slot ? 2'b10 : 2'b00);
        return e;
    endfunction

    task automatic model_step(input exp_t e);
        m_stall_cnt += (e.stall || e.frz) ? 1 : 0;
        m_flush_cnt += e.flush ? 1 : 0;
        if (m_flush_slot) begin
            m_flush_slot = 0;
        end else if (m_waiting) begin
            if (e.frz) begin
                if (m_wait_cycles < 255) m_wait_cycles++;
            end else begin
                m_waiting     = 0;
                m_wait_cycles = 0;
                m_flush_slot  = e.flush;
            end
        end else if (e.frz) begin
            m_waiting     = 1;
            m_wait_cycles = 1;
        end else begin
            m_flush_slot = e.flush;
        end
        if (m_wait_cycles >= 16) m_timed_out = 1;
    endtask

    localparam ins_t IDLE = '{default: '0, rdy: 1'b1};
    localparam exp_t ZERO = '{default: '0};

    vec_t vt[8];

    initial begin
        ins_t v;
        exp_t e;
        int frz_seen;

        // Reset holds every output low even with hazards on the inputs.
        reset = 1'b1;
        v = '{default: '0, rd_ex: 5'd5, memread: 1'b1, rs1_id: 5'd5, use1: 1'b1,
              rs1_ex: 5'd3, rd_mem: 5'd3, rwm: 1'b1, br: 1'b1, req: 1'b1, rdy: 1'b0};
        drive(v);
        #2;
        check_out("reset", ZERO);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(IDLE);
        #1 check_out("idle", ZERO);

        // Single-cycle decode vectors, all in RUN.
        vt[0] = '{in: '{default: '0, rdy: 1'b1, rs1_ex: 5'd3, rs2_ex: 5'd7, rd_mem: 5'd3, rwm: 1'b1, rd_wb: 5'd3, rwb: 1'b1},
                  ex: '{default: '0, fa: 2'b01}};
        vt[1] = '{in: '{default: '0, rdy: 1'b1, rs1_ex: 5'd0, rd_mem: 5'd0, rwm: 1'b1, rd_wb: 5'd0, rwb: 1'b1},
                  ex: '{default: '0}};
        vt[2] = '{in: '{default: '0, rdy: 1'b1, rs1_ex: 5'd4, rs2_ex: 5'd4, rd_mem: 5'd4, rd_wb: 5'd4, rwb: 1'b1},
                  ex: '{default: '0, fa: 2'b10, fb: 2'b10}};
        vt[3] = '{in: '{default: '0, rdy: 1'b1, rs1_ex: 5'd1, rs2_ex: 5'd9, rd_mem: 5'd9, rwm: 1'b1, rd_wb: 5'd9, rwb: 1'b1},
                  ex: '{default: '0, fb: 2'b01}};
        vt[4] = '{in: '{default: '0, rdy: 1'b1, memread: 1'b1, rd_ex: 5'd7, rs2_id: 5'd7, use2: 1'b1},
                  ex: '{default: '0, stall: 1'b1}};
        vt[5] = '{in: '{default: '0, rdy: 1'b1, memread: 1'b1, rd_ex: 5'd7, rs2_id: 5'd7, use2: 1'b0},
                  ex: '{default: '0}};
        vt[6] = '{in: '{default: '0, rdy: 1'b1, memread: 1'b1, rd_ex: 5'd0, rs1_id: 5'd0, use1: 1'b1},
                  ex: '{default: '0}};
        vt[7] = '{in: '{default: '0, rdy: 1'b1, memread: 1'b0, rd_ex: 5'd6, rs1_id: 5'd6, use1: 1'b1},
                  ex: '{default: '0}};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vt[i].in);
            #1 check_out($sformatf("vec%0d", i), vt[i].ex);
        end

        // lw x5,0(x1) in EX, add x6,x5,x2 in ID.
        @(negedge clk);
        v = '{default: '0, rdy: 1'b1, memread: 1'b1, rd_ex: 5'd5,
              rs1_id: 5'd5, rs2_id: 5'd2, use1: 1'b1, use2: 1'b1};
        drive(v);
        #1 check_out("lu_stall", '{default: '0, stall: 1'b1});
        @(negedge clk);
        v = '{default: '0, rdy: 1'b1, rs1_id: 5'd5, rs2_id: 5'd2, use1: 1'b1, use2: 1'b1,
              rd_mem: 5'd5, rwm: 1'b0};
        drive(v);
        #1 check_out("lu_bubble", ZERO);
        @(negedge clk);
        v = '{default: '0, rdy: 1'b1, rs1_ex: 5'd5, rs2_ex: 5'd2, rd_wb: 5'd5, rwb: 1'b1};
        drive(v);
        #1 check_out("lu_fwd", '{default: '0, fa: 2'b10});

        // Branch together with a load-use hazard: flush wins.
        @(negedge clk);
        v = '{default: '0, rdy: 1'b1, br: 1'b1, memread: 1'b1, rd_ex: 5'd5,
              rs1_id: 5'd5, use1: 1'b1};
        drive(v);
        #1 check_out("br_lu", '{default: '0, flush: 1'b1});
        @(negedge clk);
        drive(IDLE);
        #1 check_out("br_flush_state", '{default: '0, st: 2'b10});
        @(negedge clk);
        #1 check_out("br_back_run", ZERO);

        // Three wait cycles.
        frz_seen = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            v = '{default: '0, req: 1'b1, rdy: 1'b0};
            drive(v);
            #1;
            frz_seen += bus.freeze ? 1 : 0;
            chk($sformatf("w3 state%0d", k), 32'(bus.ctrl_state), (k == 1) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        v = '{default: '0, req: 1'b1, rdy: 1'b1};
        drive(v);
        #1 check_out("w3_exit", '{default: '0, st: 2'b01});
        @(negedge clk);
        drive(IDLE);
        #1 check_out("w3_run", ZERO);
        chk("w3 freeze cycles", 32'(frz_seen), 32'd3);

        // Branch held in EX across a freeze is taken on the exit cycle.
        @(negedge clk);
        v = '{default: '0, req: 1'b1, rdy: 1'b0, br: 1'b1};
        drive(v);
        #1 check_out("brfz_enter", '{default: '0, frz: 1'b1});
        @(negedge clk);
        #1 check_out("brfz_wait", '{default: '0, frz: 1'b1, st: 2'b01});
        @(negedge clk);
        v.rdy = 1'b1;
        drive(v);
        #1 check_out("brfz_exit", '{default: '0, flush: 1'b1, st: 2'b01});
        @(negedge clk);
        drive(IDLE);
        #1 check_out("brfz_flush", '{default: '0, st: 2'b10});

        // Twenty wait cycles: timeout on the 16th and sticky afterwards.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            v = '{default: '0, req: 1'b1, rdy: 1'b0};
            drive(v);
            #1 chk($sformatf("to freeze%0d", k), 32'(bus.freeze), 32'd1);
            @(posedge clk);
            #1 chk($sformatf("to flag%0d", k), 32'(bus.mem_timeout), (k >= 16) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        v.rdy = 1'b1;
        drive(v);
        #1 check_out("to_exit", '{default: '0, to: 1'b1, st: 2'b01});
        @(negedge clk);
        drive(IDLE);
        #1 check_out("to_sticky", '{default: '0, to: 1'b1});

        // Asynchronous reset in the middle of a wait.
        @(negedge clk);
        v = '{default: '0, req: 1'b1, rdy: 1'b0};
        drive(v);
        @(negedge clk);
        v = '{default: '0, req: 1'b1, rdy: 1'b0, br: 1'b1, memread: 1'b1, rd_ex: 5'd2,
              rs1_id: 5'd2, use1: 1'b1, rs1_ex: 5'd6, rd_mem: 5'd6, rwm: 1'b1};
        drive(v);
        #1 check_out("rst_pre", '{default: '0, frz: 1'b1, fa: 2'b01, to: 1'b1, st: 2'b01});
        #2 reset = 1'b1;
        #1 check_out("rst_async", ZERO);
`ifdef PIPELINE_CTRL_PERF_EN
        chk("rst perf_stall_cnt", perf_stall_cnt, 32'd0);
        chk("rst perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        drive(IDLE);
        #1 check_out("rst_release", ZERO);

        // Randomized run against the model.
        m_waiting = 0; m_flush_slot = 0; m_wait_cycles = 0; m_timed_out = 0;
        m_stall_cnt = 0; m_flush_cnt = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            v.rs1_id  = 5'($urandom_range(0, 3));
            v.rs2_id  = 5'($urandom_range(0, 3));
            v.use1    = 1'($urandom_range(0, 1));
            v.use2    = 1'($urandom_range(0, 1));
            v.rs1_ex  = 5'($urandom_range(0, 3));
            v.rs2_ex  = 5'($urandom_range(0, 3));
            v.rd_ex   = 5'($urandom_range(0, 3));
            v.memread = 1'($urandom_range(0, 1));
            v.rd_mem  = 5'($urandom_range(0, 3));
            v.rwm     = 1'($urandom_range(0, 1));
            v.rd_wb   = 5'($urandom_range(0, 3));
            v.rwb     = 1'($urandom_range(0, 1));
            v.br      = ($urandom_range(0, 6) == 0);
            v.req     = ($urandom_range(0, 3) == 0);
            v.rdy     = ($urandom_range(0, 2) != 0);
            drive(v);
            e = model_exp(v);
            #1 check_out($sformatf("rnd%0d", c), e);
            model_step(e);
        end
        @(negedge clk);
        drive(IDLE);
`ifdef PIPELINE_CTRL_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stall_cnt));
        chk("perf_flush_cnt", perf_flush_cnt, 32'(m_flush_cnt));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage RV32I pipeline in `cpu_top`. It holds or bubbles the PC, IF/ID and ID/EX registers. It handles load-use hazards, taken-branch flushes and data-memory wait states, and produces ALU operand forwarding selects for the EX stage. It is instantiated once inside `cpu_top`, beside the stage registers it controls.

## Interface
- `WAIT_LIMIT`, 16: maximum data-memory wait cycles before `mem_timeout` is flagged.
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rs1_id`, `rs2_id`  in  5  source registers of the instruction in ID.
- `use_rs1_id`, `use_rs2_id`  in  1  instruction in ID actually reads that source.
- `rs1_ex`, `rs2_ex`  in  5  source registers of the instruction in EX.
- `rd_ex`  in  5;  `memread_ex`  in  1  destination and load flag of the instruction in EX.
- `rd_mem`  in  5;  `regwrite_mem`  in  1  EX/MEM writeback info.
- `rd_wb`  in  5;  `regwrite_wb`  in  1  MEM/WB writeback info.
- `branch_taken_ex`  in  1  branch/jump resolved taken in EX.
- `dmem_req`  in  1;  `dmem_ready`  in  1  MEM-stage access request and completion.
- `stall_if`  out  1  hold PC.
- `stall_id`  out  1  hold IF/ID.
- `bubble_ex`  out  1  load NOP into ID/EX.
- `flush_ifid`, `flush_idex`  out  1  squash IF/ID and ID/EX.
- `freeze`  out  1  hold every pipeline register, including MEM/WB writes.
- `fwd_a`, `fwd_b`  out  2  operand select: 00 register file, 01 EX/MEM, 10 MEM/WB.
- `mem_timeout`  out  1  sticky error flag.
- `ctrl_state`  out  2  current FSM state, for debug.

## Operation
- FSM states: RUN (00), MEM_WAIT (01), FLUSH (10).
- RUN → MEM_WAIT when `dmem_req && !dmem_ready`. `freeze` is asserted combinationally in that same cycle.
- MEM_WAIT: `freeze` stays asserted while `!dmem_ready`. The 8-bit wait counter increments each cycle.
  - Exit to RUN on the cycle `dmem_ready` is sampled high. `freeze` deasserts in that cycle.
  - When the counter reaches `WAIT_LIMIT`, `mem_timeout` sets and holds until reset. The wait continues.
- RUN → FLUSH when `branch_taken_ex && !freeze`. `flush_ifid` and `flush_idex` are asserted that cycle.
- FLUSH lasts exactly one cycle and returns to RUN. During FLUSH, load-use detection is suppressed, because ID holds a flushed slot.
- Load-use hazard, detected in RUN only. The condition is `memread_ex`, `rd_ex != 0`, and (`use_rs1_id && rs1_id == rd_ex` or `use_rs2_id && rs2_id == rd_ex`).
  - Response: `stall_if`, `stall_id` and `bubble_ex` are asserted for one cycle.
- Priority: freeze > flush > load-use stall.
  - A branch arriving during freeze is honoured on the first unfrozen cycle.
  - A branch and a load-use hazard in the same cycle: flush only, no stall.
- Forwarding, evaluated for each of `rs1_ex` and `rs2_ex`:
  - Select 01 if `regwrite_mem && rd_mem != 0 && rd_mem == rs`.
  - Otherwise select 10 if `regwrite_wb && rd_wb != 0 && rd_wb == rs`.
  - Otherwise select 00.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.

## Timing
- Control outputs are combinational from the inputs and the registered state. State, wait counter, `mem_timeout` and perf counters update on the rising edge of `clk`.
- While `reset` is high: state RUN, wait counter 0, `mem_timeout` 0, perf counters 0. All outputs are 0 (`ctrl_state` 00, `fwd_a`/`fwd_b` 00).
- Load-use penalty is 1 cycle. Taken-branch penalty is 2 squashed slots. Memory wait penalty equals the number of cycles `dmem_ready` stays low.
- Reset asserted mid-wait or mid-flush forces RUN immediately, asynchronously. No pending stall or flush survives.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined adds `perf_stall_cnt` (out 32) and `perf_flush_cnt` (out 32).
  - `perf_stall_cnt` counts cycles in which any of `stall_if` or `freeze` is asserted.
  - `perf_flush_cnt` counts FLUSH entries.
  - Both counters wrap at 2^32.
- `PIPELINE_CTRL_PERF_EN` undefined: these ports and their counters are absent. All other behaviour is identical.

## Structure
- `pipeline_ctrl_pkg` holds:
  - the state enum (RUN/MEM_WAIT/FLUSH);
  - the forward-select constants `FWD_RF`, `FWD_MEM`, `FWD_WB`;
  - the x0 register index constant.
- Sub-module `fwd_sel` holds the forwarding compare for one operand. It is instantiated twice, for operand A and operand B.

## Test plan
- EX=`lw x5,0(x1)`, ID=`add x6,x5,x2` → one cycle of `stall_if`=`stall_id`=`bubble_ex`=1. Next cycle `fwd_a`=10.
- `rd_mem`=3 with `regwrite_mem`, `rd_wb`=3 with `regwrite_wb`, `rs1_ex`=3 → `fwd_a`=01. With `rs1_ex`=0 and both writers on x0 → `fwd_a`=00.
- `branch_taken_ex`=1 together with a load-use hazard → `flush_ifid`=`flush_idex`=1, no stall. `ctrl_state` is 10 for one cycle, then 00.
- `dmem_req`=1 with `dmem_ready` low for 3 cycles → `freeze` high for exactly 3 cycles, `ctrl_state`=01, then RUN. `mem_timeout` stays 0.
- `dmem_ready` held low for 20 cycles with `WAIT_LIMIT`=16 → `mem_timeout` rises on the 16th wait cycle and stays high after `dmem_ready` returns.
- Reset pulse during MEM_WAIT → all outputs 0 immediately, state RUN. With `PIPELINE_CTRL_PERF_EN` defined, both perf counters read 0.
